// File: rtl/retry_pkg.sv
// Shared types and width helpers for the retry tracking buffer.
package retry_pkg;

    typedef enum logic [1:0] {
        ST_FREE = 2'd0,
        ST_WAIT = 2'd1,
        ST_PEND = 2'd2,
        ST_DROP = 2'd3
    } ent_st_e;

    function automatic int tag_w(input int entries);
        return (entries > 1) ? $clog2(entries) : 1;
    endfunction

    function automatic int qos_w(input int classes);
        return (classes > 1) ? $clog2(classes) : 1;
    endfunction

endpackage

// File: rtl/retry_prio_arb.sv
// N-way arbiter: one-hot grant to the highest-QoS requester, lowest index on ties.
module retry_prio_arb #(
    parameter int N  = 32,
    parameter int QW = 2
) (
    input  logic [N-1:0]         req,
    input  logic [N-1:0][QW-1:0] qos,
    output logic [N-1:0]         gnt
);

    logic [QW-1:0] best;
    logic          found;

    // Strictly-greater compare keeps the earlier (lower) index on a tie.
    always_comb begin
        gnt   = '0;
        best  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && (!found || qos[i] > best)) begin
                gnt    = '0;
                gnt[i] = 1'b1;
                best   = qos[i];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/retry_track_buffer.sv
// Tag-tracked retry store: holds issued transactions until acked, re-offers them on
// timeout (highest QoS first) and drops them after MAX_RETRY retransmissions.
module retry_track_buffer
    import retry_pkg::*;
#(
    parameter int ENTRY_NUM     = 32,
    parameter int QOS_CLASS_NUM = 4,
    parameter int SRC_NODE_W    = 2,
    parameter int PAYLD_BW      = 8,
    parameter int TIMEOUT_CYC   = 16,
    parameter int MAX_RETRY     = 3,
    parameter int TAG_W         = tag_w(ENTRY_NUM),
    parameter int QOS_W         = qos_w(QOS_CLASS_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [QOS_W-1:0]      qos_in,
    input  logic [SRC_NODE_W-1:0] dst_id,
    input  logic [PAYLD_BW-1:0]   payload_in,
    output logic [TAG_W-1:0]      wr_tag,
    input  logic                  ack_valid,
    input  logic [TAG_W-1:0]      ack_tag,
    output logic                  rt_valid,
    input  logic                  rt_ready,
    output logic [QOS_W-1:0]      rt_qos,
    output logic [SRC_NODE_W-1:0] rt_dst_id,
    output logic [PAYLD_BW-1:0]   rt_payload,
    output logic [TAG_W-1:0]      rt_tag,
    output logic                  drop_valid,
    output logic [TAG_W-1:0]      drop_tag,
    output logic [TAG_W:0]        occupancy
);

    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam int RC_W  = $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC);
    localparam logic [RC_W-1:0]  RC_MAX   = RC_W'(MAX_RETRY);

    ent_st_e                              st_q   [ENTRY_NUM];
    ent_st_e                              st_d   [ENTRY_NUM];
    logic [TMR_W-1:0]                     tmr_q  [ENTRY_NUM];
    logic [TMR_W-1:0]                     tmr_d  [ENTRY_NUM];
    logic [RC_W-1:0]                      rcnt_q [ENTRY_NUM];
    logic [RC_W-1:0]                      rcnt_d [ENTRY_NUM];
    logic [SRC_NODE_W-1:0]                dst_q  [ENTRY_NUM];
    logic [SRC_NODE_W-1:0]                dst_d  [ENTRY_NUM];
    logic [PAYLD_BW-1:0]                  pld_q  [ENTRY_NUM];
    logic [PAYLD_BW-1:0]                  pld_d  [ENTRY_NUM];
    logic [ENTRY_NUM-1:0][QOS_W-1:0]      qos_q;
    logic [ENTRY_NUM-1:0][QOS_W-1:0]      qos_d;
    logic                                 lock_q, lock_d;
    logic [TAG_W-1:0]                     lock_idx_q, lock_idx_d;

    logic                 free_any, drop_any, arb_any;
    logic [TAG_W-1:0]     free_idx, drop_idx, arb_idx, sel_idx;
    logic [ENTRY_NUM-1:0] pend_req, gnt, ack_hit;
    logic [TAG_W:0]       occ;
    logic                 wr_fire, rt_fire;

    // Descending scan: the last hit written is the lowest index.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        drop_any = 1'b0;
        drop_idx = '0;
        pend_req = '0;
        occ      = '0;
        for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                free_any = 1'b1;
                free_idx = TAG_W'(i);
            end else begin
                occ = occ + {{TAG_W{1'b0}}, 1'b1};
            end
            if (st_q[i] == ST_DROP) begin
                drop_any = 1'b1;
                drop_idx = TAG_W'(i);
            end
            pend_req[i] = (st_q[i] == ST_PEND);
        end
    end

    retry_prio_arb #(
        .N  (ENTRY_NUM),
        .QW (QOS_W)
    ) u_rt_arb (
        .req (pend_req),
        .qos (qos_q),
        .gnt (gnt)
    );

    always_comb begin
        arb_any = |gnt;
        arb_idx = '0;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            if (gnt[i]) arb_idx = arb_idx | TAG_W'(i);
            ack_hit[i] = ack_valid && (ack_tag == TAG_W'(i));
        end
    end

    // A stalled offer stays pinned to its entry until consumed or acked away.
    always_comb begin
        sel_idx  = lock_q ? lock_idx_q : arb_idx;
        rt_valid = lock_q ? (st_q[sel_idx] == ST_PEND) : arb_any;
        rt_fire  = rt_valid && rt_ready;
        wr_fire  = wr_valid && free_any;
    end

    assign wr_ready   = free_any;
    assign wr_tag     = free_idx;
    assign drop_valid = drop_any;
    assign drop_tag   = drop_idx;
    assign occupancy  = occ;
    assign rt_qos     = rt_valid ? qos_q[sel_idx] : '0;
    assign rt_dst_id  = rt_valid ? dst_q[sel_idx] : '0;
    assign rt_payload = rt_valid ? pld_q[sel_idx] : '0;
    assign rt_tag     = rt_valid ? sel_idx : '0;

    // Per-entry FSM; ack always takes precedence over timeout and consumption.
    always_comb begin
        qos_d = qos_q;
        for (int i = 0; i < ENTRY_NUM; i++) begin
            st_d[i]   = st_q[i];
            tmr_d[i]  = tmr_q[i];
            rcnt_d[i] = rcnt_q[i];
            dst_d[i]  = dst_q[i];
            pld_d[i]  = pld_q[i];
            case (st_q[i])
                ST_FREE: begin
                    if (wr_fire && (free_idx == TAG_W'(i))) begin
                        st_d[i]   = ST_WAIT;
                        tmr_d[i]  = TMR_LOAD;
                        rcnt_d[i] = '0;
                        qos_d[i]  = qos_in;
                        dst_d[i]  = dst_id;
                        pld_d[i]  = payload_in;
                    end
                end
                ST_WAIT: begin
                    if (ack_hit[i]) begin
                        st_d[i] = ST_FREE;
                    end else if (tmr_q[i] == TMR_W'(1)) begin
                        st_d[i] = (rcnt_q[i] < RC_MAX) ? ST_PEND : ST_DROP;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TMR_W'(1);
                    end
                end
                ST_PEND: begin
                    if (ack_hit[i]) begin
                        st_d[i] = ST_FREE;
                    end else if (rt_fire && (sel_idx == TAG_W'(i))) begin
                        st_d[i]   = ST_WAIT;
                        tmr_d[i]  = TMR_LOAD;
                        rcnt_d[i] = rcnt_q[i] + RC_W'(1);
                    end
                end
                ST_DROP: begin
                    if (drop_idx == TAG_W'(i)) st_d[i] = ST_FREE;
                end
                default: st_d[i] = ST_FREE;
            endcase
        end
        lock_d     = rt_valid && !rt_ready && !(ack_valid && (ack_tag == sel_idx));
        lock_idx_d = sel_idx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                st_q[i]   <= ST_FREE;
                tmr_q[i]  <= '0;
                rcnt_q[i] <= '0;
                dst_q[i]  <= '0;
                pld_q[i]  <= '0;
            end
            qos_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            for (int i = 0; i < ENTRY_NUM; i++) begin
                st_q[i]   <= st_d[i];
                tmr_q[i]  <= tmr_d[i];
                rcnt_q[i] <= rcnt_d[i];
                dst_q[i]  <= dst_d[i];
                pld_q[i]  <= pld_d[i];
            end
            qos_q      <= qos_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
        end
    end

endmodule

// File: tb/tb_retry_track_buffer.sv
// Bench for retry_track_buffer: directed scenarios plus a randomized run against a
// deadline-based reference model.
module tb_retry_track_buffer;

    localparam int N   = 32;
    localparam int TMO = 16;
    localparam int MR  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0, ack_valid = 1'b0, rt_ready = 1'b0;
    logic       wr_ready, rt_valid, drop_valid;
    logic [1:0] qos_in = '0, dst_id = '0, rt_qos, rt_dst_id;
    logic [7:0] payload_in = '0, rt_payload;
    logic [4:0] wr_tag, ack_tag = '0, rt_tag, drop_tag;
    logic [5:0] occupancy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    retry_track_buffer dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .qos_in(qos_in), .dst_id(dst_id),
        .payload_in(payload_in), .wr_tag(wr_tag),
        .ack_valid(ack_valid), .ack_tag(ack_tag),
        .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_qos(rt_qos), .rt_dst_id(rt_dst_id),
        .rt_payload(rt_payload), .rt_tag(rt_tag),
        .drop_valid(drop_valid), .drop_tag(drop_tag), .occupancy(occupancy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; ack_valid = 1'b0; rt_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] q, input logic [1:0] d, input logic [7:0] p);
        wr_valid = 1'b1; qos_in = q; dst_id = d; payload_in = p;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_ack(input logic [4:0] t);
        ack_valid = 1'b1; ack_tag = t;
        tick();
        ack_valid = 1'b0;
    endtask

    task automatic test_reset();
        logic [35:0] got, exp;
        do_reset();
        got = {wr_ready, wr_tag, rt_valid, rt_qos, rt_dst_id, rt_payload, rt_tag, drop_valid, drop_tag, occupancy};
        exp = {1'b1, 5'd0, 1'b0, 2'd0, 2'd0, 8'd0, 5'd0, 1'b0, 5'd0, 6'd0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL reset_outputs got=%h exp=%h", got, exp); end
    endtask

    task automatic test_ack_basic();
        int seen = 0;
        do_reset();
        checks++;
        if (wr_tag !== 5'd0) begin failures++; $display("FAIL ack_basic_wr_tag got=%0d exp=0", wr_tag); end
        do_write(2'd1, 2'd2, 8'hA5);
        checks++;
        if (occupancy !== 6'd1) begin failures++; $display("FAIL ack_basic_occ1 got=%0d exp=1", occupancy); end
        repeat (3) tick();
        do_ack(5'd0);
        checks++;
        if (occupancy !== 6'd0) begin failures++; $display("FAIL ack_basic_occ0 got=%0d exp=0", occupancy); end
        for (int k = 0; k < 3 * TMO; k++) begin
            if (rt_valid === 1'b1) seen++;
            tick();
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL ack_basic_no_rt got=%0d exp=0", seen); end
    endtask

    task automatic test_retry_drop();
        int rt_at[4];
        int nrt = 0, drop_at = -1, bad = 0;
        logic [4:0] dtag = 5'h1f;
        do_reset();
        rt_ready = 1'b1;
        do_write(2'd1, 2'd2, 8'hA5);
        for (int k = 0; k < 5 * TMO; k++) begin
            if (rt_valid === 1'b1) begin
                if (nrt < 4) rt_at[nrt] = k;
                nrt++;
                if (rt_payload !== 8'hA5 || rt_tag !== 5'd0 || rt_qos !== 2'd1 || rt_dst_id !== 2'd2) bad++;
            end
            if (drop_valid === 1'b1) begin drop_at = k; dtag = drop_tag; end
            tick();
        end
        rt_ready = 1'b0;
        checks++;
        if (nrt != 3) begin failures++; $display("FAIL retry_count got=%0d exp=3", nrt); end
        checks++;
        if (nrt >= 1 && rt_at[0] != TMO) begin failures++; $display("FAIL retry_first_latency got=%0d exp=%0d", rt_at[0], TMO); end
        checks++;
        if (nrt >= 3 && (rt_at[1] != 2 * TMO + 1 || rt_at[2] != 3 * TMO + 2)) begin
            failures++; $display("FAIL retry_spacing got=%0d,%0d exp=%0d,%0d", rt_at[1], rt_at[2], 2 * TMO + 1, 3 * TMO + 2);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL retry_fields got=%0d bad exp=0", bad); end
        checks++;
        if (drop_at != 4 * TMO + 3 || dtag !== 5'd0) begin
            failures++; $display("FAIL drop_report got=cycle%0d tag%0d exp=cycle%0d tag0", drop_at, dtag, 4 * TMO + 3);
        end
        checks++;
        if (occupancy !== 6'd0) begin failures++; $display("FAIL drop_occ got=%0d exp=0", occupancy); end
    endtask

    task automatic test_fill();
        int bad = 0;
        do_reset();
        for (int i = 0; i < N; i++) begin
            if (wr_ready !== 1'b1 || wr_tag !== 5'(i)) bad++;
            do_write(2'(i % 4), 2'(i % 3), 8'(i));
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL fill_alloc_order got=%0d bad exp=0", bad); end
        checks++;
        if (wr_ready !== 1'b0 || occupancy !== 6'd32) begin
            failures++; $display("FAIL fill_full got=ready%0d occ%0d exp=ready0 occ32", wr_ready, occupancy);
        end
        wr_valid = 1'b1;
        repeat (3) tick();
        wr_valid = 1'b0;
        checks++;
        if (occupancy !== 6'd32) begin failures++; $display("FAIL fill_hold got=%0d exp=32", occupancy); end
        ack_valid = 1'b1; ack_tag = 5'd7;
        checks++;
        if (wr_ready !== 1'b0) begin failures++; $display("FAIL fill_ack_same_cycle got=%0d exp=0", wr_ready); end
        tick();
        ack_valid = 1'b0;
        checks++;
        if (wr_ready !== 1'b1 || wr_tag !== 5'd7) begin
            failures++; $display("FAIL fill_realloc got=ready%0d tag%0d exp=ready1 tag7", wr_ready, wr_tag);
        end
    endtask

    task automatic test_qos_order();
        logic [4:0] ord[3];
        int got = 0;
        do_reset();
        do_write(2'd0, 2'd0, 8'h10);
        do_write(2'd3, 2'd1, 8'h21);
        do_write(2'd3, 2'd2, 8'h22);
        do_ack(5'd0);
        checks++;
        if (wr_tag !== 5'd0) begin failures++; $display("FAIL qos_realloc_tag got=%0d exp=0", wr_tag); end
        do_write(2'd0, 2'd3, 8'h20);
        repeat (2 * TMO) tick();
        rt_ready = 1'b1;
        for (int k = 0; k < 8 && got < 3; k++) begin
            if (rt_valid === 1'b1) begin ord[got] = rt_tag; got++; end
            tick();
        end
        rt_ready = 1'b0;
        checks++;
        if (got != 3 || ord[0] !== 5'd1 || ord[1] !== 5'd2 || ord[2] !== 5'd0) begin
            failures++; $display("FAIL qos_order got=%0d:%0d,%0d,%0d exp=3:1,2,0", got, ord[0], ord[1], ord[2]);
        end
    endtask

    task automatic test_lock();
        int bad = 0, seen = 0;
        do_reset();
        do_write(2'd0, 2'd1, 8'h11);
        repeat (8) tick();
        do_write(2'd3, 2'd2, 8'h3C);
        for (int k = 0; k < 30; k++) begin
            if (rt_valid === 1'b1) begin seen++; if (rt_tag !== 5'd0) bad++; end
            tick();
        end
        checks++;
        if (seen == 0 || bad != 0) begin failures++; $display("FAIL lock_hold got=seen%0d bad%0d exp=bad0", seen, bad); end
        checks++;
        if (rt_valid !== 1'b1 || rt_tag !== 5'd0 || rt_qos !== 2'd0 || rt_payload !== 8'h11) begin
            failures++; $display("FAIL lock_fields got=v%0d t%0d q%0d p%h exp=v1 t0 q0 p11", rt_valid, rt_tag, rt_qos, rt_payload);
        end
        rt_ready = 1'b1;
        tick();
        rt_ready = 1'b0;
        checks++;
        if (rt_valid !== 1'b1 || rt_tag !== 5'd1 || rt_qos !== 2'd3 || rt_payload !== 8'h3C) begin
            failures++; $display("FAIL lock_release got=v%0d t%0d q%0d p%h exp=v1 t1 q3 p3c", rt_valid, rt_tag, rt_qos, rt_payload);
        end
    endtask

    task automatic test_ack_timeout_race();
        int seen = 0;
        do_reset();
        rt_ready = 1'b1;
        do_write(2'd2, 2'd1, 8'h5A);
        repeat (TMO - 1) tick();
        checks++;
        if (rt_valid !== 1'b0 || occupancy !== 6'd1) begin
            failures++; $display("FAIL race_pre got=v%0d occ%0d exp=v0 occ1", rt_valid, occupancy);
        end
        do_ack(5'd0);
        checks++;
        if (occupancy !== 6'd0) begin failures++; $display("FAIL race_freed got=%0d exp=0", occupancy); end
        for (int k = 0; k < 5 * TMO; k++) begin
            if (rt_valid === 1'b1 || drop_valid === 1'b1) seen++;
            tick();
        end
        rt_ready = 1'b0;
        checks++;
        if (seen != 0) begin failures++; $display("FAIL race_quiet got=%0d exp=0", seen); end
    endtask

    task automatic test_reset_mid();
        logic [35:0] got, exp;
        do_reset();
        do_write(2'd1, 2'd1, 8'h01);
        do_write(2'd2, 2'd2, 8'h02);
        do_write(2'd3, 2'd3, 8'h03);
        repeat (TMO + 8) tick();
        checks++;
        if (rt_valid !== 1'b1 || occupancy !== 6'd3) begin
            failures++; $display("FAIL midrst_pre got=v%0d occ%0d exp=v1 occ3", rt_valid, occupancy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        got = {wr_ready, wr_tag, rt_valid, rt_qos, rt_dst_id, rt_payload, rt_tag, drop_valid, drop_tag, occupancy};
        exp = {1'b1, 5'd0, 1'b0, 2'd0, 2'd0, 8'd0, 5'd0, 1'b0, 5'd0, 6'd0};
        checks++;
        if (got !== exp) begin failures++; $display("FAIL midrst_outputs got=%h exp=%h", got, exp); end
    endtask

    // Reference: each live tag carries an absolute deadline and a retransmit count.
    task automatic test_random();
        bit         m_busy[N];
        int         m_due[N];
        int         m_try[N];
        logic [1:0] m_q[N];
        logic [1:0] m_d[N];
        logic [7:0] m_p[N];
        int now = 0, lock_t = -1;
        int ft, drp, sel, bq, occ, ak;
        do_reset();
        for (int i = 0; i < N; i++) begin m_busy[i] = 1'b0; m_due[i] = 0; m_try[i] = 0; end
        for (int cyc = 0; cyc < 4000; cyc++) begin
            wr_valid   = ($urandom_range(0, 3) != 0);
            qos_in     = 2'($urandom_range(0, 3));
            dst_id     = 2'($urandom_range(0, 3));
            payload_in = 8'($urandom_range(0, 255));
            ack_valid  = (cyc < 2000) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
            ack_tag    = 5'($urandom_range(0, N - 1));
            rt_ready   = ($urandom_range(0, 2) != 0);
            ft = -1; drp = -1; sel = -1; bq = -1; occ = 0;
            for (int i = 0; i < N; i++) begin
                if (!m_busy[i]) begin
                    if (ft < 0) ft = i;
                end else begin
                    occ++;
                    if (now >= m_due[i]) begin
                        if (m_try[i] >= MR) begin
                            if (drp < 0) drp = i;
                        end else if (int'(m_q[i]) > bq) begin
                            bq = int'(m_q[i]); sel = i;
                        end
                    end
                end
            end
            if (lock_t >= 0) sel = lock_t;
            checks++;
            if ({wr_ready, rt_valid, drop_valid, occupancy} !== {ft >= 0, sel >= 0, drp >= 0, 6'(occ)}) begin
                failures++;
                $display("FAIL rand_status cyc=%0d got=wr%0d rt%0d dr%0d occ%0d exp=wr%0d rt%0d dr%0d occ%0d", cyc,
                         wr_ready, rt_valid, drop_valid, occupancy, ft >= 0, sel >= 0, drp >= 0, occ);
            end
            if (ft >= 0) begin
                checks++;
                if (wr_tag !== 5'(ft)) begin failures++; $display("FAIL rand_wr_tag cyc=%0d got=%0d exp=%0d", cyc, wr_tag, ft); end
            end
            if (drp >= 0) begin
                checks++;
                if (drop_tag !== 5'(drp)) begin failures++; $display("FAIL rand_drop_tag cyc=%0d got=%0d exp=%0d", cyc, drop_tag, drp); end
            end
            if (sel >= 0) begin
                checks++;
                if ({rt_tag, rt_qos, rt_dst_id, rt_payload} !== {5'(sel), m_q[sel], m_d[sel], m_p[sel]}) begin
                    failures++;
                    $display("FAIL rand_rt cyc=%0d got=t%0d q%0d d%0d p%h exp=t%0d q%0d d%0d p%h", cyc,
                             rt_tag, rt_qos, rt_dst_id, rt_payload, sel, m_q[sel], m_d[sel], m_p[sel]);
                end
            end
            tick();
            ak = -1;
            if (ack_valid && m_busy[ack_tag] && !(now >= m_due[ack_tag] && m_try[ack_tag] >= MR)) begin
                ak = int'(ack_tag);
                m_busy[ak] = 1'b0;
            end
            if (sel >= 0 && rt_ready && sel != ak) begin
                m_try[sel]++;
                m_due[sel] = now + 1 + TMO;
            end
            if (drp >= 0) m_busy[drp] = 1'b0;
            if (wr_valid && ft >= 0) begin
                m_busy[ft] = 1'b1; m_due[ft] = now + 1 + TMO; m_try[ft] = 0;
                m_q[ft] = qos_in; m_d[ft] = dst_id; m_p[ft] = payload_in;
            end
            lock_t = (sel >= 0 && !rt_ready && sel != ak) ? sel : -1;
            now++;
        end
        wr_valid = 1'b0; ack_valid = 1'b0; rt_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ack_basic();
        test_retry_drop();
        test_fill();
        test_qos_order();
        test_lock();
        test_ack_timeout_race();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
